// File: rtl/cam_stream_gen.sv
// OV7670-style parallel pixel source: drives p_clock/vsync/href/p_data like the sensor,
// producing RGB565 test-pattern frames (single-shot or continuous) for loopback of the capture path.
module cam_stream_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 144,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 3,
  parameter int VBP_LINES   = 17,
  parameter int VFP_LINES   = 10,
  parameter int PCLK_HALF   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_en,
  input  logic        cont_mode,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_color,
  output logic        p_clock,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  p_data,
  output logic        busy,
  output logic        frame_done
);

  localparam int LINE_BYTES = 2 * (H_ACTIVE + H_BLANK);
  localparam int ACT_BYTES  = 2 * H_ACTIVE;
  localparam int BAR_W      = H_ACTIVE / 8;
  localparam int MAX_AB     = (VSYNC_LINES > VBP_LINES) ? VSYNC_LINES : VBP_LINES;
  localparam int MAX_CD     = (V_ACTIVE > VFP_LINES) ? V_ACTIVE : VFP_LINES;
  localparam int MAX_SEG    = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int BYTE_W     = $clog2(LINE_BYTES);
  localparam int SEG_W      = $clog2(MAX_SEG + 1);
  localparam int ROW_W      = $clog2(V_ACTIVE + 1);
  localparam int DIV_W      = $clog2(PCLK_HALF + 1);
  localparam int BARP_W     = $clog2(BAR_W + 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_VSYNC  = 3'd1;
  localparam logic [2:0] ST_VBP    = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_VFP    = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  // Counters address the byte to be presented at the NEXT fall event; outputs are registered from them.
  logic [2:0]        state, state_nxt;
  logic [DIV_W-1:0]  div_cnt;
  logic [BYTE_W-1:0] byte_cnt;
  logic [SEG_W-1:0]  seg_line;
  logic [ROW_W-1:0]  row_cnt;
  logic [2:0]        bar_cnt;
  logic [BARP_W-1:0] bar_pix;
  logic [7:0]        fcnt;
  logic [1:0]        pattern_q;
  logic [15:0]       solid_q;
  logic              pending;

  logic        div_last, fall_evt, start_frame, seg_last, in_href;
  logic [4:0]  col_lo;
  logic [5:0]  row_lo;
  logic [15:0] bar_color, pix_color;
  logic [7:0]  data_nxt;

  assign div_last    = (int'(div_cnt) == PCLK_HALF - 1);
  assign fall_evt    = div_last && p_clock;
  assign start_frame = fall_evt && ((state == ST_IDLE && pending) || (state == ST_DONE && cont_mode));
  assign in_href     = (state == ST_ACTIVE) && (int'(byte_cnt) < ACT_BYTES);
  assign col_lo      = 5'(byte_cnt >> 1);
  assign row_lo      = 6'(row_cnt);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    seg_last  = 1'b0;
    state_nxt = ST_IDLE;
    case (state)
      ST_VSYNC:  begin seg_last = (int'(seg_line) == VSYNC_LINES - 1); state_nxt = ST_VBP;    end
      ST_VBP:    begin seg_last = (int'(seg_line) == VBP_LINES - 1);   state_nxt = ST_ACTIVE; end
      ST_ACTIVE: begin seg_last = (int'(seg_line) == V_ACTIVE - 1);    state_nxt = ST_VFP;    end
      ST_VFP:    begin seg_last = (int'(seg_line) == VFP_LINES - 1);   state_nxt = ST_DONE;   end
      default:   begin seg_last = 1'b0;                                state_nxt = ST_IDLE;   end
    endcase
  end

  always_comb begin
    bar_color = 16'h0000;
    case (bar_cnt)
      3'd0:    bar_color = 16'hFFFF;
      3'd1:    bar_color = 16'hFFE0;
      3'd2:    bar_color = 16'h07FF;
      3'd3:    bar_color = 16'h07E0;
      3'd4:    bar_color = 16'hF81F;
      3'd5:    bar_color = 16'hF800;
      3'd6:    bar_color = 16'h001F;
      default: bar_color = 16'h0000;
    endcase
  end

  always_comb begin
    pix_color = 16'h0000;
    case (pattern_q)
      2'd0:    pix_color = bar_color;
      2'd1:    pix_color = {col_lo, row_lo, fcnt[4:0]};
      2'd2:    pix_color = solid_q;
      default: pix_color = (col_lo[3] ^ row_lo[3]) ? 16'hFFFF : 16'h0000;
    endcase
    data_nxt = 8'h00;
    if (in_href) data_nxt = byte_cnt[0] ? pix_color[7:0] : pix_color[15:8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_clock    <= 1'b0;
      vsync      <= 1'b0;
      href       <= 1'b0;
      p_data     <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      div_cnt    <= '0;
      byte_cnt   <= '0;
      seg_line   <= '0;
      row_cnt    <= '0;
      bar_cnt    <= '0;
      bar_pix    <= '0;
      fcnt       <= '0;
      pattern_q  <= '0;
      solid_q    <= '0;
      pending    <= 1'b0;
      state      <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      frame_done <= 1'b0;
      if (div_last) begin
        div_cnt <= '0;
        p_clock <= ~p_clock;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end

      if (state == ST_IDLE && start_en) pending <= 1'b1;

      if (fall_evt) begin
        if (state == ST_DONE) begin
          frame_done <= 1'b1;
          fcnt       <= fcnt + 8'd1;
        end

        if (start_frame) begin
          // Byte 0 of line 0 is presented now, so the counters jump straight to byte 1.
          pending   <= 1'b0;
          busy      <= 1'b1;
          vsync     <= 1'b1;
          href      <= 1'b0;
          p_data    <= 8'h00;
          state     <= ST_VSYNC;
          seg_line  <= '0;
          byte_cnt  <= BYTE_W'(1);
          row_cnt   <= '0;
          bar_cnt   <= '0;
          bar_pix   <= '0;
          pattern_q <= pattern_sel;
          solid_q   <= solid_color;
        end else if (state == ST_DONE) begin
          busy     <= 1'b0;
          vsync    <= 1'b0;
          href     <= 1'b0;
          p_data   <= 8'h00;
          state    <= ST_IDLE;
          byte_cnt <= '0;
          seg_line <= '0;
          row_cnt  <= '0;
        end else if (state != ST_IDLE) begin
          vsync  <= (state == ST_VSYNC);
          href   <= in_href;
          p_data <= data_nxt;
          if (int'(byte_cnt) == LINE_BYTES - 1) begin
            byte_cnt <= '0;
            bar_cnt  <= '0;
            bar_pix  <= '0;
            if (state == ST_ACTIVE) row_cnt <= row_cnt + ROW_W'(1);
            if (seg_last) begin
              seg_line <= '0;
              state    <= state_nxt;
            end else begin
              seg_line <= seg_line + SEG_W'(1);
            end
          end else begin
            byte_cnt <= byte_cnt + BYTE_W'(1);
            if (in_href && byte_cnt[0]) begin
              if (int'(bar_pix) == BAR_W - 1) begin
                bar_pix <= '0;
                bar_cnt <= bar_cnt + 3'd1;
              end else begin
                bar_pix <= bar_pix + BARP_W'(1);
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: doc/cam_stream_gen.md
Name: cam_stream_gen

Overview:
- Synthesizable OV7670-style parallel pixel source. It is the transmitting end of the camera parallel bus: it drives p_clock, vsync, href and p_data exactly as the sensor does.
- Its outputs connect directly to the camera_io pixel inputs for on-board loopback and simulation of the capture/binning path without a sensor.
- Generates RGB565 frames from selectable test patterns, one frame per start or continuously.

Parameters:
- H_ACTIVE, 640: active pixels per line. Must be a multiple of 8.
- H_BLANK, 144: blank pixel periods per line (href low).
- V_ACTIVE, 480: active lines per frame.
- VSYNC_LINES, 3: lines with vsync high.
- VBP_LINES, 17: blank lines after vsync.
- VFP_LINES, 10: blank lines after the last active line.
- PCLK_HALF, 2: clk cycles per p_clock half-period (≥1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start_en  in  1  one-clk pulse; requests a frame when idle
- cont_mode  in  1  1 = repeat frames back-to-back; sampled at frame end
- pattern_sel  in  2  0 colour bars, 1 coordinate, 2 solid, 3 checker; sampled at frame start
- solid_color  in  16  RGB565 value for pattern 2; sampled at frame start
- p_clock  out  1  free-running pixel clock, clk/(2*PCLK_HALF)
- vsync  out  1  frame sync, active high
- href  out  1  line valid, active high
- p_data  out  8  byte stream
- busy  out  1  high from frame start to frame end
- frame_done  out  1  one-clk pulse after the last byte period of a frame

Behaviour:
- Reset: p_clock=0, vsync=0, href=0, p_data=8'h00, busy=0, frame_done=0, divider=0, all counters=0, state=IDLE, pending=0. Reset asserted mid-frame aborts the frame; outputs return to reset values at the next clk edge.
- p_clock toggles every PCLK_HALF clk cycles, including in IDLE. A "fall event" is the clk cycle in which p_clock is registered 1→0.
- vsync, href and p_data update only at fall events. They are therefore stable across each p_clock rising edge; the sink samples on rising edges.
- start_en sets pending when state=IDLE. It is ignored while busy. Pending is cleared at the next fall event, which begins the frame: busy=1, line=0, byte=0. pattern_sel and solid_color are latched at this point.
- Line length: 2*(H_ACTIVE+H_BLANK) byte periods.
- Frame length: FL = VSYNC_LINES+VBP_LINES+V_ACTIVE+VFP_LINES lines.
- States:
  - VSYNC: lines 0..VSYNC_LINES-1, vsync=1.
  - VBP: next VBP_LINES lines.
  - ACTIVE: next V_ACTIVE lines.
  - VFP: remaining lines.
  - Transitions happen on line counter wrap.
- href=1 only in ACTIVE, for bytes 0..2*H_ACTIVE-1 of the line. p_data=00 whenever href=0.
- Each pixel is two bytes: first {R[4:0],G[5:3]}, second {G[2:0],B[4:0]}.
- Coordinates: col = pixel index in line; row = active line index; fcnt = 8-bit frame counter, incremented at frame end.
- Pattern 0, colour bars: 8 bars of width H_ACTIVE/8, in order FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000. Bar index is held in a counter; no divider.
- Pattern 1, coordinate: R=col[4:0], G=row[5:0], B=fcnt[4:0].
- Pattern 2, solid: latched solid_color.
- Pattern 3, checker: (col[3]^row[3]) ? FFFF : 0000.
- Frame end, at the fall event that would begin byte 0 of line FL:
  - frame_done pulses for one clk.
  - If cont_mode=1, the next frame starts at that same fall event with vsync=1 and busy held at 1.
  - Otherwise busy=0, vsync=0, state=IDLE.
  - start_en arriving during the last byte period is ignored.
- Counter widths are sized from the parameters; no wrap occurs inside a frame.

Test Plan:
All scenarios use H_ACTIVE=8, H_BLANK=2, V_ACTIVE=4, VSYNC_LINES=1, VBP_LINES=1, VFP_LINES=1, PCLK_HALF=1. This gives a line of 20 bytes (40 clk) and a frame of 7 lines (280 clk).
1. Reset, then 10 idle clks → p_clock toggles every clk; vsync/href/busy=0; p_data=00.
2. start_en pulse, pattern 0 → vsync high for exactly 40 clk. Then 4 href pulses, each 32 clk high. First line bytes FF FF FF E0 07 FF 07 E0 F8 1F F8 00 00 1F 00 00. frame_done pulses once 280 clk after frame start; busy then drops.
3. Pattern 1, two frames with cont_mode=1 → byte pair for col=3, row=2 is 18 40 (frame 0) then 18 41 (frame 1). The second vsync rises in the same fall event as the first frame_done.
4. Pattern 2, solid_color=A5C3 → every href-high byte pair is A5 C3. solid_color changed mid-frame has no effect until the next frame.
5. start_en pulse mid-frame, and pattern_sel changed mid-frame → no restart; the frame completes unchanged and the block returns to IDLE.
6. reset asserted at clk 150 of a frame → all outputs at reset values at the next clk. start_en after reset release produces a full, correct frame.
